// File: rtl/mips150_mem_stage.sv
// MIPS150 memory-access stage: turns decoded load/store controls into a single
// req/ack data-memory transaction, stalling the pipeline until it completes.
module mips150_mem_stage #(
    parameter int ACK_TIMEOUT = 255,
    parameter int DMEM_AW     = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic               mem_to_reg,
    input  logic [2:0]         mask,
    input  logic [1:0]         mem_write,
    input  logic [31:0]        addr,
    input  logic [31:0]        store_data,
    output logic               stall,
    output logic               load_valid,
    output logic [31:0]        load_data,
    output logic               misaligned,
    output logic               bus_error,
    output logic               dmem_req,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ack,
    input  logic [31:0]        dmem_rdata
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t          state;
    logic [CW-1:0]   count;
    logic            ld_q;
    logic            sext_q;
    logic [1:0]      size_q;
    logic [1:0]      off_q;

    logic            is_store;
    logic            mem_op;
    logic            aligned;
    logic            accept;
    logic [1:0]      size_n;
    logic            sext_n;
    logic [3:0]      we_n;
    logic [31:0]     wdata_n;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [31:0]     fmt;

    // A store always wins over a load; the load mask only matters for loads.
    always_comb begin
        is_store = (mem_write != 2'b00);
        size_n   = SZ_WORD;
        sext_n   = 1'b0;
        if (is_store) begin
            case (mem_write)
                2'b01:   size_n = SZ_BYTE;
                2'b10:   size_n = SZ_HALF;
                default: size_n = SZ_WORD;
            endcase
        end else begin
            case (mask)
                3'b000: begin size_n = SZ_BYTE; sext_n = 1'b1; end
                3'b001: begin size_n = SZ_HALF; sext_n = 1'b1; end
                3'b011: size_n = SZ_BYTE;
                3'b100: size_n = SZ_HALF;
                default: size_n = SZ_WORD;
            endcase
        end

        case (size_n)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~addr[0];
            default: aligned = (addr[1:0] == 2'b00);
        endcase

        mem_op = valid_in & (is_store | mem_to_reg);

        we_n    = 4'b0000;
        wdata_n = 32'h0;
        if (is_store) begin
            case (size_n)
                SZ_BYTE: begin
                    we_n    = 4'b1000 >> addr[1:0];
                    wdata_n = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    we_n    = addr[1] ? 4'b0011 : 4'b1100;
                    wdata_n = {2{store_data[15:0]}};
                end
                default: begin
                    we_n    = 4'b1111;
                    wdata_n = store_data;
                end
            endcase
        end
    end

    assign accept = (state == IDLE) & mem_op & aligned;

    // Big-endian lane extraction from the word returned with ack.
    always_comb begin
        case (off_q)
            2'd0:    sel_byte = dmem_rdata[31:24];
            2'd1:    sel_byte = dmem_rdata[23:16];
            2'd2:    sel_byte = dmem_rdata[15:8];
            default: sel_byte = dmem_rdata[7:0];
        endcase
        sel_half = off_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        case (size_q)
            SZ_BYTE: fmt = {{24{sext_q & sel_byte[7]}}, sel_byte};
            SZ_HALF: fmt = {{16{sext_q & sel_half[15]}}, sel_half};
            default: fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            ld_q       <= 1'b0;
            sext_q     <= 1'b0;
            size_q     <= SZ_BYTE;
            off_q      <= 2'b00;
            load_data  <= 32'h0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            dmem_we    <= 4'b0000;
            dmem_addr  <= '0;
            dmem_wdata <= 32'h0;
        end else begin
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op && !aligned) begin
                        misaligned <= 1'b1;
                    end else if (accept) begin
                        ld_q       <= ~is_store;
                        sext_q     <= sext_n;
                        size_q     <= size_n;
                        off_q      <= addr[1:0];
                        dmem_we    <= we_n;
                        dmem_addr  <= addr[DMEM_AW+1:2];
                        dmem_wdata <= wdata_n;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    count <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // An ack in the final allowed cycle beats the timeout.
                    if (dmem_ack) begin
                        if (ld_q) begin
                            load_data <= fmt;
                        end
                        state <= RESP;
                    end else if ((ACK_TIMEOUT != 0) && (count == CW'(ACK_TIMEOUT - 1))) begin
                        bus_error <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dmem_req   = (state == REQ);
    assign load_valid = (state == RESP) & ld_q;
    assign stall      = accept | (state == REQ) | (state == WAIT);

endmodule

// File: tb/tb_mips150_mem_stage.sv
// Directed bench for mips150_mem_stage: a default-timeout instance for normal
// traffic and an ACK_TIMEOUT=4 instance for the abort boundary.
module tb_mips150_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, valid_to;
    logic        mem_to_reg;
    logic [2:0]  mask;
    logic [1:0]  mem_write;
    logic [31:0] addr, store_data;
    logic        dmem_ack, ack_to;
    logic [31:0] dmem_rdata;

    logic        stall, load_valid, misaligned, bus_error, dmem_req;
    logic [31:0] load_data, dmem_wdata;
    logic [3:0]  dmem_we;
    logic [29:0] dmem_addr;

    logic        to_stall, to_load_valid, to_misaligned, to_bus_error, to_dmem_req;
    logic [31:0] to_load_data, to_dmem_wdata;
    logic [3:0]  to_dmem_we;
    logic [29:0] to_dmem_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips150_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_to_reg(mem_to_reg),
        .mask(mask), .mem_write(mem_write), .addr(addr), .store_data(store_data),
        .stall(stall), .load_valid(load_valid), .load_data(load_data),
        .misaligned(misaligned), .bus_error(bus_error), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    mips150_mem_stage #(.ACK_TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_to), .mem_to_reg(mem_to_reg),
        .mask(mask), .mem_write(mem_write), .addr(addr), .store_data(store_data),
        .stall(to_stall), .load_valid(to_load_valid), .load_data(to_load_data),
        .misaligned(to_misaligned), .bus_error(to_bus_error), .dmem_req(to_dmem_req),
        .dmem_we(to_dmem_we), .dmem_addr(to_dmem_addr), .dmem_wdata(to_dmem_wdata),
        .dmem_ack(ack_to), .dmem_rdata(dmem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setOp(input logic [1:0] mw, input logic m2r, input logic [2:0] mk,
                         input logic [31:0] a, input logic [31:0] sd);
        mem_write  = mw;
        mem_to_reg = m2r;
        mask       = mk;
        addr       = a;
        store_data = sd;
    endtask

    task automatic clearOp();
        valid_in   = 1'b0;
        valid_to   = 1'b0;
        mem_write  = 2'b00;
        mem_to_reg = 1'b0;
    endtask

    // Runs one aligned access on the main instance; ackDelay counts cycles after req.
    task automatic applyStimulus(input string tag, input logic [1:0] mw, input logic m2r,
                                 input logic [2:0] mk, input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rd, input int ackDelay,
                                 input logic [3:0] expWe, input logic [31:0] expWdata,
                                 input logic [29:0] expAddr, input logic expLv,
                                 input logic [31:0] expLd, input int expStall);
        int  stallCnt = 0;
        int  reqCnt   = 0;
        int  lvCnt    = 0;
        int  reqCyc   = -1;
        bit  done     = 0;
        bit  respPhase;
        setOp(mw, m2r, mk, a, sd);
        dmem_rdata = rd;
        valid_in   = 1'b1;
        #1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (stall) stallCnt++;
            if (dmem_req) begin
                reqCnt++;
                reqCyc = cyc;
                checkOutput({tag, " we"}, {28'h0, dmem_we}, {28'h0, expWe});
                checkOutput({tag, " addr"}, {2'b00, dmem_addr}, {2'b00, expAddr});
                if (expWe != 4'b0000)
                    checkOutput({tag, " wdata"}, dmem_wdata, expWdata);
            end
            if (load_valid) begin
                lvCnt++;
                checkOutput({tag, " load_data"}, load_data, expLd);
            end
            respPhase = (reqCyc >= 0) && !stall;
            dmem_ack  = (reqCyc >= 0) && (cyc == reqCyc + ackDelay);
            if (dmem_ack)
                checkOutput({tag, " we held"}, {28'h0, dmem_we}, {28'h0, expWe});
            tick();
            dmem_ack = 1'b0;
            if (respPhase) begin
                clearOp();
                done = 1;
            end
            #1;
        end
        if (!done) begin
            clearOp();
            checkOutput({tag, " completion"}, 32'd0, 32'd1);
        end
        checkOutput({tag, " stall cycles"}, stallCnt, expStall);
        checkOutput({tag, " req pulses"}, reqCnt, 32'd1);
        checkOutput({tag, " load_valid pulses"}, lvCnt, {31'h0, expLv});
    endtask

    task automatic misalignedRun(input string tag, input logic [1:0] mw, input logic m2r,
                                 input logic [2:0] mk, input logic [31:0] a);
        setOp(mw, m2r, mk, a, 32'h12345678);
        valid_in = 1'b1;
        #1;
        checkOutput({tag, " stall"}, {31'h0, stall}, 32'h0);
        tick();
        clearOp();
        #1;
        checkOutput({tag, " misaligned"}, {31'h0, misaligned}, 32'h1);
        checkOutput({tag, " req"}, {31'h0, dmem_req}, 32'h0);
        tick();
        #1;
        checkOutput({tag, " misaligned drop"}, {31'h0, misaligned}, 32'h0);
        checkOutput({tag, " no req"}, {31'h0, dmem_req}, 32'h0);
    endtask

    // LW on the ACK_TIMEOUT=4 instance; WAIT spans cycles 2..5, ackAt<0 means no ack.
    task automatic timeoutRun(input string tag, input int ackAt, input logic expErr,
                              input logic [31:0] rd);
        int stallCnt = 0;
        setOp(2'b00, 1'b1, 3'b010, 32'h0000_4000, 32'h0);
        dmem_rdata = rd;
        valid_to   = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (to_stall) stallCnt++;
            ack_to = (c == ackAt);
            tick();
            ack_to = 1'b0;
            if (c == 5) clearOp();
            #1;
        end
        checkOutput({tag, " stall cycles"}, stallCnt, 32'd6);
        checkOutput({tag, " stall released"}, {31'h0, to_stall}, 32'h0);
        checkOutput({tag, " bus_error"}, {31'h0, to_bus_error}, {31'h0, expErr});
        checkOutput({tag, " load_valid"}, {31'h0, to_load_valid}, {31'h0, ~expErr});
        if (!expErr)
            checkOutput({tag, " load_data"}, to_load_data, rd);
        tick();
        #1;
        checkOutput({tag, " bus_error drop"}, {31'h0, to_bus_error}, 32'h0);
        checkOutput({tag, " idle stall"}, {31'h0, to_stall}, 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        ack_to     = 1'b0;
        dmem_rdata = 32'h0;
        mask       = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        clearOp();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset stall", {31'h0, stall}, 32'h0);
        checkOutput("reset req", {31'h0, dmem_req}, 32'h0);
        checkOutput("reset we", {28'h0, dmem_we}, 32'h0);
        checkOutput("reset addr", {2'b00, dmem_addr}, 32'h0);
        checkOutput("reset wdata", dmem_wdata, 32'h0);
        checkOutput("reset load_data", load_data, 32'h0);
        rst_n = 1'b1;
        tick();

        applyStimulus("SB 1003", 2'b01, 1'b0, 3'b000, 32'h0000_1003, 32'hAABBCC5A, 32'h0, 1,
                      4'b0001, 32'h5A5A5A5A, 30'h400, 1'b0, 32'h0, 3);
        applyStimulus("LB 2001", 2'b00, 1'b1, 3'b000, 32'h0000_2001, 32'h0, 32'h11F02233, 1,
                      4'b0000, 32'h0, 30'h800, 1'b1, 32'hFFFFFFF0, 3);
        applyStimulus("LBU 2001", 2'b00, 1'b1, 3'b011, 32'h0000_2001, 32'h0, 32'h11F02233, 1,
                      4'b0000, 32'h0, 30'h800, 1'b1, 32'h000000F0, 3);
        applyStimulus("LH 2002", 2'b00, 1'b1, 3'b001, 32'h0000_2002, 32'h0, 32'h1234ABCD, 1,
                      4'b0000, 32'h0, 30'h800, 1'b1, 32'hFFFFABCD, 3);
        applyStimulus("SH 2002", 2'b10, 1'b0, 3'b000, 32'h0000_2002, 32'h55667788, 32'h0, 1,
                      4'b0011, 32'h77887788, 30'h800, 1'b0, 32'h0, 3);
        applyStimulus("LW slow ack", 2'b00, 1'b1, 3'b010, 32'h0000_2004, 32'h0, 32'hDEADBEEF, 5,
                      4'b0000, 32'h0, 30'h801, 1'b1, 32'hDEADBEEF, 7);
        applyStimulus("LHU 2000", 2'b00, 1'b1, 3'b100, 32'h0000_2000, 32'h0, 32'h80011234, 1,
                      4'b0000, 32'h0, 30'h800, 1'b1, 32'h00008001, 3);
        applyStimulus("SW 2008", 2'b11, 1'b0, 3'b000, 32'h0000_2008, 32'hCAFEF00D, 32'h0, 2,
                      4'b1111, 32'hCAFEF00D, 30'h802, 1'b0, 32'h0, 4);
        applyStimulus("SB beats load", 2'b01, 1'b1, 3'b010, 32'h0000_2001, 32'h000000A5, 32'h0, 1,
                      4'b0100, 32'hA5A5A5A5, 30'h800, 1'b0, 32'h0, 3);
        checkOutput("load_data held", load_data, 32'h00008001);

        misalignedRun("LW 3002", 2'b00, 1'b1, 3'b010, 32'h0000_3002);
        misalignedRun("SH 3001", 2'b10, 1'b0, 3'b000, 32'h0000_3001);
        misalignedRun("mask101 3001", 2'b00, 1'b1, 3'b101, 32'h0000_3001);

        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        #1;
        checkOutput("stray ack stall", {31'h0, stall}, 32'h0);
        checkOutput("stray ack load_valid", {31'h0, load_valid}, 32'h0);
        checkOutput("stray ack req", {31'h0, dmem_req}, 32'h0);

        timeoutRun("timeout", -1, 1'b1, 32'h0BADF00D);
        timeoutRun("ack on last cycle", 5, 1'b0, 32'h13572468);

        setOp(2'b00, 1'b1, 3'b010, 32'h0000_5000, 32'h0);
        valid_in = 1'b1;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        clearOp();
        #1;
        checkOutput("mid reset stall", {31'h0, stall}, 32'h0);
        checkOutput("mid reset req", {31'h0, dmem_req}, 32'h0);
        checkOutput("mid reset we", {28'h0, dmem_we}, 32'h0);
        checkOutput("mid reset addr", {2'b00, dmem_addr}, 32'h0);
        checkOutput("mid reset load_data", load_data, 32'h0);
        tick();
        rst_n = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF0000;
        tick();
        dmem_ack = 1'b0;
        #1;
        checkOutput("late ack load_valid", {31'h0, load_valid}, 32'h0);
        checkOutput("late ack stall", {31'h0, stall}, 32'h0);
        checkOutput("late ack load_data", load_data, 32'h0);

        applyStimulus("LW after reset", 2'b00, 1'b1, 3'b010, 32'h0000_5000, 32'h0, 32'h89ABCDEF, 1,
                      4'b0000, 32'h0, 30'h1400, 1'b1, 32'h89ABCDEF, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips150_mem_stage.md
# mips150_mem_stage

Memory-access stage of the MIPS150 pipeline. It consumes the load/store controls from the control decoder (MemtoReg, Mask, MemWrite) together with the ALU-computed address and the rt store data. It issues one request per access to the data memory over a req/ack handshake, generating big-endian byte enables and replicated store data. It stalls the pipeline while an access is outstanding and returns aligned, sign- or zero-extended load data. It also flags misaligned accesses and memory timeouts.

## Interface
- ACK_TIMEOUT, 255: maximum WAIT cycles before abort; 0 disables the timeout.
- DMEM_AW, 30: width of the word address sent to data memory.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  MEM-stage instruction valid.
- mem_to_reg  in  1  load indicator from decoder.
- mask  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU; 101-111 treated as LW.
- mem_write  in  2  store type: 00 none, 01 SB, 10 SH, 11 SW.
- addr  in  32  byte address (ALU result).
- store_data  in  32  rt value.
- stall  out  1  holds all upstream pipeline registers.
- load_valid  out  1  one-cycle pulse; load_data is valid.
- load_data  out  32  aligned/extended load result.
- misaligned  out  1  one-cycle pulse: access dropped.
- bus_error  out  1  one-cycle pulse: ack timeout.
- dmem_req  out  1  one-cycle request pulse.
- dmem_we  out  4  byte enables; we[3] = bits 31:24; 0000 = read.
- dmem_addr  out  DMEM_AW  addr[DMEM_AW+1:2].
- dmem_wdata  out  32  replicated store data.
- dmem_ack  in  1  one-cycle completion; dmem_rdata valid in same cycle.
- dmem_rdata  in  32  read word.

## Operation
- Op qualification: mem_op = valid_in & (mem_write != 0 | mem_to_reg). If both a store and a load are indicated, the store wins.
- Alignment:
  - Halfword ops (LH, LHU, SH) require addr[0] = 0.
  - Word ops (LW, SW) require addr[1:0] = 00.
  - On violation: no request is issued, misaligned pulses for 1 cycle, stall stays 0, and no load_valid is produced.
- Stores (big-endian lanes):
  - SB: we = 1000 >> addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: we = 1100 (addr[1] = 0) or 0011 (addr[1] = 1); wdata = {2{store_data[15:0]}}.
  - SW: we = 1111; wdata = store_data.
- Loads use we = 0000. The decoder's mask value is ignored for stores.
- Load extraction is from the rdata captured at ack:
  - Byte k = addr[1:0] selects bits [31-8k:24-8k].
  - Half selects [31:16] when addr[1] = 0, otherwise [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Address, type and offset are registered at accept; load formatting uses the registered copies.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: on an aligned mem_op, register the request and go to REQ; otherwise stay in IDLE.
  - REQ: dmem_req = 1; go to WAIT. dmem_ack is ignored in this state.
  - WAIT: on dmem_ack go to RESP. If the counter reaches ACK_TIMEOUT (nonzero), pulse bus_error and go to IDLE.
  - RESP: load_valid = 1 if the access was a load; go to IDLE unconditionally.
- Stall: stall = (IDLE & aligned mem_op) | REQ | WAIT. Stall is 0 in RESP, so the pipeline advances at the end of RESP; the held instruction is never reissued.
- dmem_ack in IDLE, REQ or RESP is ignored (stray or late ack).
- dmem_addr, dmem_we and dmem_wdata remain stable from REQ until leaving WAIT.

## Timing
- Reset (async assert, sync release): state IDLE, timeout counter 0, all outputs 0 (dmem_we 0000, dmem_addr 0, dmem_wdata 0, load_data 0).
- Reset mid-access abandons the transaction; a later ack is ignored.
- Minimum access:
  - cycle 0: accept, stall = 1;
  - cycle 1: REQ, dmem_req = 1;
  - cycle 2: ack earliest;
  - cycle 3: RESP, load_valid = 1, stall = 0.
- Minimum stall is 3 cycles per access; each extra ack-wait cycle adds 1.
- Timeout counter:
  - Cleared on entry to WAIT; increments each WAIT cycle without ack.
  - Abort occurs in the WAIT cycle where count == ACK_TIMEOUT - 1 and ack = 0; stall drops the next cycle.
  - Ack arriving in that same cycle wins (go to RESP, no error).
- misaligned and bus_error are registered outputs, asserted in the cycle after the triggering condition.
- load_data holds its value until the next load's RESP.

## Test plan
- SB: addr 0x1003, store_data 0xAABBCC5A -> dmem_we 0001, dmem_wdata 0x5A5A5A5A, dmem_addr 0x400, stall high for 3 cycles, no load_valid.
- LB vs LBU: addr 0x2001, rdata 0x11F02233 -> LB load_data 0xFFFFFFF0; LBU 0x000000F0; load_valid in cycle 3.
- LH at addr 0x2002 with rdata 0x1234ABCD -> 0xFFFFABCD. SH at 0x2002 -> we 0011, wdata {2{store_data[15:0]}}.
- Misaligned: LW at 0x3002 and SH at 0x3001 -> misaligned pulse, dmem_req never asserted, stall 0.
- Delayed ack: ack 5 cycles after req -> stall high for 7 cycles; stray ack in IDLE causes no change. With ACK_TIMEOUT = 4 and no ack -> bus_error, return to IDLE, no load_valid.
- rst_n low during WAIT, then ack after release -> outputs 0, state IDLE, ack ignored; the next LW completes normally.
